// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MIPS memory stage.
package mem_stage_pkg;

    localparam int unsigned STALL_WD  = 6;
    localparam int unsigned EX_MEM_WD = 76;
    localparam int unsigned MEM_WB_WD = 70;
    localparam int unsigned MEM_ID_WD = 38;
    localparam int unsigned LOAD_WD   = 5;

    // Stall vector encoding
    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    // Bit positions inside {inst_lb, inst_lbu, inst_lh, inst_lhu, inst_lw}
    localparam int unsigned LD_LW  = 0;
    localparam int unsigned LD_LHU = 1;
    localparam int unsigned LD_LH  = 2;
    localparam int unsigned LD_LBU = 3;
    localparam int unsigned LD_LB  = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StHold = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Selects the addressed byte/half/word of a load and sign- or zero-extends it.
module mem_stage_load_extend
    import mem_stage_pkg::*;
(
    input  logic [31:0]        rdata,
    input  logic [3:0]         sel,
    input  logic [LOAD_WD-1:0] load_flags,
    output logic [31:0]        wdata
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane pick from the byte-enable pattern; unexpected patterns give zero data
    always_comb begin
        byte_v = 8'h00;
        half_v = 16'h0000;
        case (sel)
            4'b0001: byte_v = rdata[7:0];
            4'b0010: byte_v = rdata[15:8];
            4'b0100: byte_v = rdata[23:16];
            4'b1000: byte_v = rdata[31:24];
            default: byte_v = 8'h00;
        endcase
        case (sel)
            4'b0011: half_v = rdata[15:0];
            4'b1100: half_v = rdata[31:16];
            default: half_v = 16'h0000;
        endcase
    end

    // Extension by load type; flags are one-hot from decode
    always_comb begin
        wdata = 32'h0;
        if (load_flags[LD_LB]) begin
            wdata = {{24{byte_v[7]}}, byte_v};
        end else if (load_flags[LD_LBU]) begin
            wdata = {24'h0, byte_v};
        end else if (load_flags[LD_LH]) begin
            wdata = {{16{half_v[15]}}, half_v};
        end else if (load_flags[LD_LHU]) begin
            wdata = {16'h0, half_v};
        end else if (load_flags[LD_LW]) begin
            wdata = rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: registers the execute bus, waits for SRAM read data,
// extends load data and drives the writeback and decode-forwarding buses.
// Optional macro MEM_ADDR_CHECK_EN adds misaligned-load detection (port mem_adel).
module mem_stage #(
    parameter int unsigned STALL_WD  = 6,
    parameter int unsigned EX_MEM_WD = 76,
    parameter int unsigned MEM_WB_WD = 70
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [STALL_WD-1:0]  stall,
    input  logic [EX_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [4:0]           load_sram_ex_data,
    input  logic [3:0]           data_ram_sel,
    input  logic [31:0]          data_sram_rdata,
    input  logic                 data_sram_rvalid,
    output logic [MEM_WB_WD-1:0] mem_to_wb_bus,
    output logic [37:0]          mem_to_id_bus,
    output logic                 stallreq_for_mem
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                 mem_adel
`endif
);
    import mem_stage_pkg::*;

    logic [EX_MEM_WD-1:0] bus_q;
    logic [LOAD_WD-1:0]   load_q;
    logic [3:0]           sel_q;
    mem_state_e           state_q, state_d;
    logic [31:0]          rdata_buf_q;
    logic                 buf_capture;

    logic [31:0] pc, ex_result, rdata_src, load_wdata, rf_wdata;
    logic [4:0]  rf_waddr;
    logic        ram_en, sel_rf_res, rf_we, is_load, wait_load, adel, rf_we_out;

    // Pipeline register: clear on reset or bubble, capture when not stalled, else hold
    always_ff @(posedge clk) begin
        if (rst || (stall[3] == Stop && stall[4] == NoStop)) begin
            bus_q  <= '0;
            load_q <= '0;
            sel_q  <= '0;
        end else if (stall[3] == NoStop) begin
            bus_q  <= ex_to_mem_bus;
            load_q <= load_sram_ex_data;
            sel_q  <= data_ram_sel;
        end
    end

    assign pc         = bus_q[75:44];
    assign ram_en     = bus_q[43];
    assign sel_rf_res = bus_q[38];
    assign rf_we      = bus_q[37];
    assign rf_waddr   = bus_q[36:32];
    assign ex_result  = bus_q[31:0];
    assign is_load    = (|load_q) & ram_en;

`ifdef MEM_ADDR_CHECK_EN
    // Misaligned halfword/word loads raise an address error and never wait for data
    assign adel = is_load & (((load_q[LD_LH] | load_q[LD_LHU]) & ex_result[0]) |
                             (load_q[LD_LW] & (ex_result[1:0] != 2'b00)));
    assign mem_adel = adel;
`else
    assign adel = 1'b0;
`endif
    assign wait_load = is_load & ~adel;

    // FSM next state; a stage left without a load always returns to idle
    always_comb begin
        state_d     = state_q;
        buf_capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (wait_load) begin
                    if (!data_sram_rvalid) begin
                        state_d = StWait;
                    end else if (stall[3] == Stop) begin
                        // Data is here but the load cannot leave yet: keep a copy
                        state_d     = StHold;
                        buf_capture = 1'b1;
                    end
                end
            end
            StWait: begin
                if (!wait_load) begin
                    state_d = StIdle;
                end else if (data_sram_rvalid) begin
                    if (stall[3] == NoStop) begin
                        state_d = StIdle;
                    end else begin
                        state_d     = StHold;
                        buf_capture = 1'b1;
                    end
                end
            end
            StHold: begin
                if (!wait_load || stall[3] == NoStop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and captured read data
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rdata_buf_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (buf_capture) rdata_buf_q <= data_sram_rdata;
        end
    end

    assign rdata_src = (state_q == StHold) ? rdata_buf_q : data_sram_rdata;

    mem_stage_load_extend u_load_extend (
        .rdata      (rdata_src),
        .sel        (sel_q),
        .load_flags (load_q),
        .wdata      (load_wdata)
    );

    // Output buses; forwarding is suppressed while load data is outstanding
    always_comb begin
        stallreq_for_mem = wait_load & ~(data_sram_rvalid | (state_q == StHold));
        rf_wdata         = sel_rf_res ? load_wdata : ex_result;
        rf_we_out        = rf_we & ~adel;
        mem_to_wb_bus    = {pc, rf_we_out, rf_waddr, rf_wdata};
        mem_to_id_bus    = {rf_we_out & ~stallreq_for_mem, rf_waddr, rf_wdata};
    end

endmodule
